// File: rtl/instr_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_ctrl_pkg
// Shared definitions for the instruction memory controller: default geometry,
// loader FSM state encoding, fetch fault bit positions and a small helper that
// assembles the fault vector.
// ----------------------------------------------------------------------------
package instr_mem_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_AW    = 64;

  // fetch_fault = {out_of_range, misaligned}
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [1:0] fault_bits(input logic out_of_range,
                                            input logic misaligned);
    logic [1:0] f;
    f                 = 2'b00;
    f[FAULT_RANGE]    = out_of_range;
    f[FAULT_MISALIGN] = misaligned;
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_imem_array.sv
// ----------------------------------------------------------------------------
// imem_array
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port. The read register can be cleared explicitly so a faulted fetch
// presents an all-zero word on the following cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write word index
//   i_wdata  in   write data
//   i_re     in   read enable (loads read register from the array)
//   i_rclr   in   clear read register to zero (takes priority over i_re)
//   i_raddr  in   read word index
//   o_rdata  out  registered read data
// ----------------------------------------------------------------------------
module imem_array
  import instr_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic             i_rclr,
  input  logic [IW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array contents are deliberately not reset: a reset in the middle of a
  // load session must leave already written words intact.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rclr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// ----------------------------------------------------------------------------
// instr_mem_ctrl
// Instruction memory with a fetch port (1-cycle latency, full throughput,
// alignment/range fault reporting) and a streaming loader that writes a run
// of consecutive words starting at a byte base address. While the loader
// owns the memory (LOAD and DONE) fetch requests are ignored and
// fetch_stall is high.
//
// Loader FSM
//   state | meaning
//   IDLE  | fetches serviced; load_start opens a session
//   LOAD  | load_ready=1, one word written per load_valid transfer
//   DONE  | load_done pulse for one cycle, then back to IDLE
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   fetch_req    in   fetch request
//   fetch_addr   in   fetch byte address (AW)
//   fetch_rdata  out  registered instruction word (WIDTH)
//   fetch_valid  out  fetch result valid
//   fetch_fault  out  {out_of_range, misaligned}, valid with fetch_valid
//   fetch_stall  out  loader owns the memory
//   load_start   in   open a load session at load_base
//   load_base    in   byte start address (AW)
//   load_valid   in   load word valid
//   load_ready   out  loader accepts a word
//   load_data    in   load word (WIDTH)
//   load_last    in   final word of the session
//   load_done    out  one-cycle pulse at session end
//   load_err     out  sticky overflow / bad base flag
// ----------------------------------------------------------------------------
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [AW-1:0]    fetch_addr,
  output logic [WIDTH-1:0] fetch_rdata,
  output logic             fetch_valid,
  output logic [1:0]       fetch_fault,
  output logic             fetch_stall,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_done,
  output logic             load_err
);

  localparam int BL   = WIDTH / 8;
  localparam int OFFW = $clog2(BL);
  localparam int IW   = $clog2(DEPTH);

  localparam logic [AW-1:0] LANE_MASK = AW'(BL - 1);
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [IW-1:0] PTR_MAX   = IW'(DEPTH - 1);

  state_e r_state;
  state_e w_next_state;

  logic [IW-1:0] r_ptr;
  logic          r_load_err;
  logic          r_fetch_valid;
  logic [1:0]    r_fetch_fault;

  logic          w_load_ready;
  logic          w_load_done;
  logic          w_stall;
  logic          w_we;
  logic          w_set_err;
  logic          w_clr_err;
  logic          w_ptr_load;
  logic          w_ptr_inc;

  // --------------------------------------------------------------------------
  // Address decode: word index is the byte address with the lane bits dropped.
  // The range check uses the full-width index so high address bits are never
  // silently truncated into a valid index.
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_fetch_widx;
  logic          w_fetch_misal;
  logic          w_fetch_oor;
  logic [1:0]    w_fetch_fault;
  logic          w_fetch_acc;

  logic [AW-1:0] w_base_widx;
  logic          w_base_misal;
  logic          w_base_oor;

  assign w_fetch_widx  = fetch_addr >> OFFW;
  assign w_fetch_misal = |(fetch_addr & LANE_MASK);
  assign w_fetch_oor   = (w_fetch_widx >= DEPTH_A);
  assign w_fetch_fault = fault_bits(w_fetch_oor, w_fetch_misal);
  assign w_fetch_acc   = fetch_req && (r_state == ST_IDLE);

  assign w_base_widx   = load_base >> OFFW;
  assign w_base_misal  = |(load_base & LANE_MASK);
  assign w_base_oor    = (w_base_widx >= DEPTH_A);

  // --------------------------------------------------------------------------
  // Loader FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_ready = 1'b0;
    w_load_done  = 1'b0;
    w_stall      = 1'b1;
    w_we         = 1'b0;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    w_ptr_load   = 1'b0;
    w_ptr_inc    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stall = 1'b0;
        if (load_start) begin
          w_clr_err  = 1'b1;
          w_ptr_load = 1'b1;
          if (w_base_misal || w_base_oor) begin
            // Bad base: end the session immediately without touching memory.
            w_next_state = ST_DONE;
            w_set_err    = 1'b1;
          end else begin
            w_next_state = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        w_load_ready = 1'b1;
        if (load_valid) begin
          w_we = 1'b1;
          if (load_last) begin
            w_next_state = ST_DONE;
          end else if (r_ptr == PTR_MAX) begin
            // Top of memory reached with more data pending: stop, no wrap.
            w_next_state = ST_DONE;
            w_set_err    = 1'b1;
          end else begin
            w_ptr_inc = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_load_done  = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Loader datapath: word pointer and sticky error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ptr_load) begin
      r_ptr <= w_base_widx[IW-1:0];
    end else if (w_ptr_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Set wins over clear so a bad base reported in the same cycle as
  // load_start is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_err <= 1'b0;
    end else if (w_set_err) begin
      r_load_err <= 1'b1;
    end else if (w_clr_err) begin
      r_load_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch pipeline: fault bits registered alongside the array read so that
  // valid, data and fault all appear on the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 2'b00;
    end else begin
      r_fetch_valid <= w_fetch_acc;
      r_fetch_fault <= w_fetch_acc ? w_fetch_fault : 2'b00;
    end
  end

  logic             w_arr_re;
  logic             w_arr_rclr;
  logic             w_arr_we;
  logic [WIDTH-1:0] w_arr_rdata;

  assign w_arr_re   = w_fetch_acc && (w_fetch_fault == 2'b00);
  assign w_arr_rclr = w_fetch_acc && (w_fetch_fault != 2'b00);
  // A reset edge never commits a write, even if a transfer is presented.
  assign w_arr_we   = w_we && !rst;

  imem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_imem_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_arr_we),
    .i_waddr (r_ptr),
    .i_wdata (load_data),
    .i_re    (w_arr_re),
    .i_rclr  (w_arr_rclr),
    .i_raddr (w_fetch_widx[IW-1:0]),
    .o_rdata (w_arr_rdata)
  );

  assign fetch_rdata = w_arr_rdata;
  assign fetch_valid = r_fetch_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_stall = w_stall;
  assign load_ready  = w_load_ready;
  assign load_done   = w_load_done;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
module tb_instr_mem_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_req;
  logic [AW-1:0]    fetch_addr;
  logic [WIDTH-1:0] fetch_rdata;
  logic             fetch_valid;
  logic [1:0]       fetch_fault;
  logic             fetch_stall;
  logic             load_start;
  logic [AW-1:0]    load_base;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_last;
  logic             load_done;
  logic             load_err;

  instr_mem_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_rdata (fetch_rdata),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .fetch_stall (fetch_stall),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       fault;
  } exp_t;

  exp_t             sb_q [$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               bptr;
  logic             exp_done = 1'b0;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    e.fault[0] = (a[1:0] != 2'b00);
    e.fault[1] = ((a >> 2) >= AW'(DEPTH));
    e.data     = (e.fault != 2'b00) ? '0 : ref_mem[int'(a >> 2)];
    return e;
  endfunction

  // One clock: sample 1 time unit after the rising edge; any queued fetch
  // expectation must be answered on exactly this cycle.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("fetch_valid", fetch_valid, 1);
      chk("fetch_rdata", fetch_rdata, e.data);
      chk("fetch_fault", fetch_fault, e.fault);
    end else begin
      chk("fetch_valid_idle", fetch_valid, 0);
    end
    chk("load_done", load_done, exp_done);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb_q.push_back(model(a));
    cycle();
  endtask

  task automatic fetch_off();
    fetch_req = 1'b0;
    cycle();
  endtask

  task automatic start(input logic [AW-1:0] base, input logic bad);
    load_start = 1'b1;
    load_base  = base;
    bptr       = int'(base >> 2);
    exp_done   = bad;
    cycle();
    load_start = 1'b0;
    exp_done   = 1'b0;
  endtask

  // v: drive load_valid, wr: bench expects this word to be written,
  // done_next: session ends on this edge.
  task automatic load_step(input logic v, input logic [WIDTH-1:0] d, input logic l,
                           input logic wr, input logic done_next);
    load_valid = v;
    load_data  = d;
    load_last  = l;
    if (wr) begin
      ref_mem[bptr] = d;
      bptr++;
    end
    exp_done = done_next;
    cycle();
    exp_done = 1'b0;
  endtask

  task automatic load_idle();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_base  = '0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("rst_rdata", fetch_rdata, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_err", load_err, 0);
    chk("rst_stall", fetch_stall, 0);
    rst = 1'b0;
    cycle();

    // Load 4 words at base 0, last on the 4th
    start(64'h0, 1'b0);
    chk("load_stall", fetch_stall, 1);
    chk("load_ready", load_ready, 1);
    load_step(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    load_step(1'b1, 32'h0010_0093, 1'b0, 1'b1, 1'b0);
    load_step(1'b1, 32'h0020_0113, 1'b0, 1'b1, 1'b0);
    load_step(1'b1, 32'h0030_0193, 1'b1, 1'b1, 1'b1);
    chk("done_err", load_err, 0);
    chk("done_ready", load_ready, 0);
    load_idle();
    cycle();
    chk("idle_stall", fetch_stall, 0);

    // Back-to-back fetches
    fetch(64'h0);
    fetch(64'h4);
    fetch(64'h8);
    fetch(64'hC);
    fetch_off();

    // Fault reporting
    fetch(64'h6);
    fetch(64'(DEPTH * 4));
    fetch(64'(DEPTH * 4 + 2));
    fetch(64'h4);
    fetch_off();

    // Overflow at top of memory: 3 words offered, only 2 accepted
    start(64'((DEPTH - 2) * 4), 1'b0);
    load_step(1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b0);
    load_step(1'b1, 32'hB000_0001, 1'b0, 1'b1, 1'b1);
    chk("ovf_err", load_err, 1);
    load_step(1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b0);
    chk("ovf_err_sticky", load_err, 1);
    chk("ovf_stall", fetch_stall, 0);
    load_idle();
    fetch(64'h0);
    fetch(64'((DEPTH - 2) * 4));
    fetch(64'((DEPTH - 1) * 4));
    fetch_off();

    // load_valid toggling: only handshaked words written, in order
    start(64'h40, 1'b0);
    chk("tog_err_cleared", load_err, 0);
    load_step(1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0);
    load_step(1'b0, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
    chk("tog_ready", load_ready, 1);
    load_step(1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0);
    load_step(1'b0, 32'hDEAD_0002, 1'b1, 1'b0, 1'b0);
    load_step(1'b1, 32'hA000_0002, 1'b1, 1'b1, 1'b1);
    load_idle();
    cycle();
    fetch(64'h40);
    fetch(64'h44);
    fetch(64'h48);
    fetch_off();

    // Misaligned base: straight to DONE with error, nothing written
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    start(64'h2, 1'b1);
    chk("bad_err", load_err, 1);
    chk("bad_stall", fetch_stall, 1);
    chk("bad_ready", load_ready, 0);
    load_idle();
    cycle();
    fetch(64'h0);
    fetch_off();

    // Fetch and load_start together: fetch serviced, following fetch stalled
    fetch_req  = 1'b1;
    fetch_addr = 64'h4;
    sb_q.push_back(model(64'h4));
    load_start = 1'b1;
    load_base  = 64'h100;
    bptr       = 64;
    cycle();
    load_start = 1'b0;
    fetch_addr = 64'h8;
    cycle();
    chk("sim_stall", fetch_stall, 1);
    fetch_req = 1'b0;
    load_step(1'b1, 32'hC0C0_0001, 1'b1, 1'b1, 1'b1);
    load_idle();
    cycle();
    fetch(64'h100);
    fetch_off();

    // Reset after 2 of 4 words: no done pulse, written words kept
    start(64'h0, 1'b0);
    load_step(1'b1, 32'hD000_0000, 1'b0, 1'b1, 1'b0);
    load_step(1'b1, 32'hD000_0001, 1'b0, 1'b1, 1'b0);
    load_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstm_stall", fetch_stall, 0);
    chk("rstm_ready", load_ready, 0);
    chk("rstm_err", load_err, 0);
    chk("rstm_rdata", fetch_rdata, 0);
    cycle();
    fetch(64'h0);
    fetch(64'h4);
    fetch(64'h8);
    fetch(64'hC);
    fetch_off();

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
